mod_sigma0: RTL and testbench

Registered SHA-256 "big sigma 0" (Σ0) function unit: Y = ROTR2(A) ^ ROTR13(A) ^ ROTR22(A) on a 32-bit word. It sits in the compression-round datapath, where it consumes working variable `a` and feeds the T2 adder. The result is captured in an output register with a valid flag, so the round pipeline can treat it as a one-cycle stage. An optional build feature adds the message-schedule "small sigma 0" (σ0) function.

---
 rtl/mod_sigma0_if.sv | 33 +++
 rtl/mod_sigma0.sv | 60 ++++++
 tb/tb_mod_sigma0.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mod_sigma0_if.sv
// mod_sigma0_if: operand/result bundle for the registered sigma-0 unit.
// Build macro SIGMA0_SMALL_EN adds the SEL function-select signal.
//   IN_VALID, A, SEL (opt) : producer -> unit
//   Y, OUT_VALID           : unit -> consumer
interface mod_sigma0_if;
    logic        IN_VALID;
    logic [0:31] A;
`ifdef SIGMA0_SMALL_EN
    logic        SEL;
`endif
    logic [0:31] Y;
    logic        OUT_VALID;

`ifdef SIGMA0_SMALL_EN
    modport master (
        output IN_VALID, A, SEL,
        input  Y, OUT_VALID
    );
    modport slave (
        input  IN_VALID, A, SEL,
        output Y, OUT_VALID
    );
`else
    modport master (
        output IN_VALID, A,
        input  Y, OUT_VALID
    );
    modport slave (
        input  IN_VALID, A,
        output Y, OUT_VALID
    );
`endif
endinterface

// File: rtl/mod_sigma0.sv
// mod_sigma0: registered SHA-256 big sigma 0, Y = ROTR2^ROTR13^ROTR22 of A.
// Macro SIGMA0_SMALL_EN adds small sigma 0 (ROTR7^ROTR18^SHR3) on SEL=1.
// Ports: CLK, RST_N (async active-low), bus (mod_sigma0_if.slave):
//   IN_VALID/A/SEL in, Y/OUT_VALID out; one-cycle latency, no stall.
module mod_sigma0 (
    input  logic        CLK,
    input  logic        RST_N,
    mod_sigma0_if.slave bus
);

    // Bit 0 is the MSB, so >> and << act on the numeric word value.
    function automatic logic [0:31] rotr(input logic [0:31] v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [0:31] big_sigma0(input logic [0:31] v);
        return rotr(v, 2) ^ rotr(v, 13) ^ rotr(v, 22);
    endfunction

`ifdef SIGMA0_SMALL_EN
    function automatic logic [0:31] small_sigma0(input logic [0:31] v);
        return rotr(v, 7) ^ rotr(v, 18) ^ (v >> 3);
    endfunction
`endif

    logic [0:31] y_q, y_d;
    logic        valid_q, valid_d;
    logic [0:31] f_res;

    always_comb begin
`ifdef SIGMA0_SMALL_EN
        f_res = bus.SEL ? small_sigma0(bus.A) : big_sigma0(bus.A);
`else
        f_res = big_sigma0(bus.A);
`endif
    end

    // Y holds its last result across idle cycles.
    always_comb begin
        y_d     = y_q;
        valid_d = bus.IN_VALID;
        if (bus.IN_VALID) begin
            y_d = f_res;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Y         = y_q;
    assign bus.OUT_VALID = valid_q;

endmodule

// File: tb/tb_mod_sigma0.sv
// tb_mod_sigma0: vector table, corner sequences and random stream
// checked against a bit-index reference model of the sigma functions.
module tb_mod_sigma0;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    mod_sigma0_if bus ();

    mod_sigma0 dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [0:31] a;
        logic        sel;
        logic [0:31] y;
    } tv_t;

    tv_t tv[$];

    // Output bit j of ROTRn comes from input bit j-n (mod 32), MSB = bit 0.
    function automatic logic [0:31] m_rotr(input logic [0:31] v, input int n);
        logic [0:31] r;
        for (int j = 0; j < 32; j++) r[j] = v[(j - n + 32) % 32];
        return r;
    endfunction

    function automatic logic [0:31] m_shr(input logic [0:31] v, input int n);
        logic [0:31] r;
        for (int j = 0; j < 32; j++) r[j] = (j < n) ? 1'b0 : v[j - n];
        return r;
    endfunction

    function automatic logic [0:31] m_f(input logic [0:31] v, input logic sel);
        if (sel) return m_rotr(v, 7) ^ m_rotr(v, 18) ^ m_shr(v, 3);
        return m_rotr(v, 2) ^ m_rotr(v, 13) ^ m_rotr(v, 22);
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [0:31] a, input logic sel);
        bus.IN_VALID = v;
        bus.A        = a;
`ifdef SIGMA0_SMALL_EN
        bus.SEL      = sel;
`else
        if (sel) $display("note: sel ignored in this build");
`endif
    endtask

    // One input per cycle: drive on falling edge, check just after rising.
    task automatic cycle(input logic v, input logic [0:31] a, input logic sel,
                         input logic [0:31] exp_y, input logic exp_v,
                         input string name);
        @(negedge CLK);
        set_in(v, a, sel);
        @(posedge CLK);
        #1;
        check({name, ".y"}, bus.Y, exp_y);
        check({name, ".v"}, {31'd0, bus.OUT_VALID}, {31'd0, exp_v});
    endtask

    logic [0:31] exp_y;
    logic        exp_v;
    logic [0:31] ra;
    logic        rv;
    logic        rs;

    initial begin
        checks   = 0;
        failures = 0;
        RST_N    = 1'b1;
        set_in(1'b0, 32'h0, 1'b0);

        tv.push_back('{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF});
        tv.push_back('{32'hFFFF0000, 1'b0, 32'hC3F83C07});
        tv.push_back('{32'hF0F0F0F0, 1'b0, 32'h78787878});
        tv.push_back('{32'hCCCCCCCC, 1'b0, 32'h66666666});
        tv.push_back('{32'h00000000, 1'b0, 32'h00000000});
        tv.push_back('{32'hAAAAAAAA, 1'b0, 32'h55555555});
`ifdef SIGMA0_SMALL_EN
        tv.push_back('{32'hFFFFFFFF, 1'b1, 32'h1FFFFFFF});
        tv.push_back('{32'h00000000, 1'b1, 32'h00000000});
        tv.push_back('{32'hFFFF0000, 1'b0, 32'hC3F83C07});
        tv.push_back('{32'hAAAAAAAA, 1'b0, 32'h55555555});
`endif

        // Asynchronous reset at power-up, away from any clock edge.
        #2 RST_N = 1'b0;
        #1;
        check("rst0.y", bus.Y, 32'h0);
        check("rst0.v", {31'd0, bus.OUT_VALID}, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // First capture happens on the first edge with reset released.
        cycle(1'b1, 32'h12345678, 1'b0, m_f(32'h12345678, 1'b0), 1'b1, "first");

        // Table vectors streamed back-to-back; valid must stay high.
        foreach (tv[i]) begin
            cycle(1'b1, tv[i].a, tv[i].sel, tv[i].y, 1'b1, $sformatf("tv%0d", i));
        end

        // Hold: idle after AAAAAAAA, toggle A between edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            set_in(1'b0, 32'h0F0F0F0F ^ k, 1'b0);
            @(posedge CLK);
            #2 bus.A = 32'hDEADBEEF;
            #1;
            check("hold.y", bus.Y, 32'h55555555);
            check("hold.v", {31'd0, bus.OUT_VALID}, 32'd0);
        end

        // Reset mid-stream while a result is valid.
        cycle(1'b1, 32'hF0F0F0F0, 1'b0, 32'h78787878, 1'b1, "pre_rst");
        #2 RST_N = 1'b0;
        #1;
        check("rst1.y", bus.Y, 32'h0);
        check("rst1.v", {31'd0, bus.OUT_VALID}, 32'd0);
        @(negedge CLK);
        set_in(1'b0, 32'h0, 1'b0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst.y", bus.Y, 32'h0);
        check("post_rst.v", {31'd0, bus.OUT_VALID}, 32'd0);

        // Random stream against the model.
        exp_y = 32'h0;
        exp_v = 1'b0;
        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            rv = 1'($urandom_range(0, 3) != 0);
`ifdef SIGMA0_SMALL_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            if (rv) exp_y = m_f(ra, rs);
            exp_v = rv;
            cycle(rv, ra, rs, exp_y, exp_v, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
